// File: rtl/page_stream_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : page_stream_bridge_if
// Description : Bundles the leaf-interface user channels (vld/ack) and the
//               kernel AXI-stream channels (TDATA/TVALID/TREADY) seen by
//               page_stream_bridge.
//               slave  = the bridge itself.
//               master = the surrounding leaf interface + user kernel.
// Revision    : 1.0 - initial release
// ============================================================================
interface page_stream_bridge_if #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 2,
  parameter int NUM_OUT_PORTS = 1
);
  // interface -> kernel direction
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user;
  logic [NUM_IN_PORTS-1:0]               vld_interface2user;
  logic [NUM_IN_PORTS-1:0]               ack_user2interface;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  Input_V_TDATA;
  logic [NUM_IN_PORTS-1:0]               Input_V_TVALID;
  logic [NUM_IN_PORTS-1:0]               Input_V_TREADY;
  // kernel -> interface direction
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] Output_V_TDATA;
  logic [NUM_OUT_PORTS-1:0]              Output_V_TVALID;
  logic [NUM_OUT_PORTS-1:0]              Output_V_TREADY;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;

  modport slave (
    input  dout_leaf_interface2user, vld_interface2user, Input_V_TREADY,
           Output_V_TDATA, Output_V_TVALID, ack_interface2user,
    output ack_user2interface, Input_V_TDATA, Input_V_TVALID,
           Output_V_TREADY, din_leaf_user2interface, vld_user2interface
  );

  modport master (
    output dout_leaf_interface2user, vld_interface2user, Input_V_TREADY,
           Output_V_TDATA, Output_V_TVALID, ack_interface2user,
    input  ack_user2interface, Input_V_TDATA, Input_V_TVALID,
           Output_V_TREADY, din_leaf_user2interface, vld_user2interface
  );
endinterface
`default_nettype wire

// File: rtl/page_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module      : page_stream_bridge
// Description : Buffering bridge between leaf-interface user channels and an
//               HLS kernel's AXI-stream ports. One FWFT FIFO per channel,
//               sticky start gating and a synchronous flush.
//               Optional per-channel push counters: PAGE_BRIDGE_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module page_stream_bridge #(
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_IN_PORTS    = 2,
  parameter int NUM_OUT_PORTS   = 1,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                                     ap_clk,
  input  logic                                     ap_rst_n,
  input  logic                                     ap_start,
  input  logic                                     flush,
  output logic                                     ap_start_user,
  page_stream_bridge_if.slave                      bus,
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*32-1:0] perf_cnt
);

  localparam int NCH   = NUM_IN_PORTS + NUM_OUT_PORTS;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int AW    = FIFO_DEPTH_BITS;
  localparam int CW    = FIFO_DEPTH_BITS + 1;
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

  // --------------------------------------------------------------------------
  // Start gating: once started, the kernel stays enabled until reset.
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state and decoded start output (output is a pure function of state)
  always_comb begin
    state_d       = state_q;
    ap_start_user = 1'b0;
    case (state_q)
      IDLE: begin
        if (ap_start) state_d = RUN;
      end
      RUN: begin
        ap_start_user = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Flatten both directions into one channel vector: input channels occupy
  // the low indices, output channels follow. This matches the perf_cnt layout.
  // --------------------------------------------------------------------------
  logic [NCH-1:0]              w_push_vld;
  logic [NCH*PAYLOAD_BITS-1:0] w_push_data;
  logic [NCH-1:0]              w_pop_rdy;
  logic [NCH-1:0]              w_wr_rdy;
  logic [NCH-1:0]              w_rd_vld;
  logic [NCH*PAYLOAD_BITS-1:0] w_rd_data;

  assign w_push_vld  = {bus.Output_V_TVALID, bus.vld_interface2user};
  assign w_push_data = {bus.Output_V_TDATA,  bus.dout_leaf_interface2user};
  assign w_pop_rdy   = {bus.ack_interface2user, bus.Input_V_TREADY};

  assign bus.ack_user2interface      = w_wr_rdy[NUM_IN_PORTS-1:0];
  assign bus.Output_V_TREADY         = w_wr_rdy[NCH-1:NUM_IN_PORTS];
  assign bus.Input_V_TVALID          = w_rd_vld[NUM_IN_PORTS-1:0];
  assign bus.vld_user2interface      = w_rd_vld[NCH-1:NUM_IN_PORTS];
  assign bus.Input_V_TDATA           = w_rd_data[NUM_IN_PORTS*PAYLOAD_BITS-1:0];
  assign bus.din_leaf_user2interface = w_rd_data[NCH*PAYLOAD_BITS-1:NUM_IN_PORTS*PAYLOAD_BITS];

  // --------------------------------------------------------------------------
  // Per-channel first-word-fall-through FIFO
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic [CW-1:0]           count_q, count_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic                    w_push;
    logic                    w_pop;

    // Ready/valid derive from the registered count only, so a pop never
    // frees space for a push in the same cycle and there is no bypass.
    assign w_wr_rdy[c] = (count_q != c_DEPTH);
    assign w_rd_vld[c] = (count_q != '0);
    assign w_rd_data[c*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_q[rd_ptr_q];

    assign w_push = w_push_vld[c] & w_wr_rdy[c];
    assign w_pop  = w_pop_rdy[c]  & w_rd_vld[c];

    // Pointer/count update; flush wins over any push or pop in the same cycle
    always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
        count_d  = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end else begin
        if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({w_push, w_pop})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end
    end

    // Control registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        count_q  <= count_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    // Storage is deliberately unreset; the count alone qualifies its contents
    always_ff @(posedge ap_clk) begin
      if (w_push) mem_q[wr_ptr_q] <= w_push_data[c*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

`ifdef PAGE_BRIDGE_PERF_CNT_EN
    logic [31:0] perf_q;

    // Accepted-push counter, wraps naturally, untouched by flush
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)   perf_q <= '0;
      else if (w_push) perf_q <= perf_q + 32'd1;
    end

    assign perf_cnt[c*32 +: 32] = perf_q;
`endif
  end

`ifndef PAGE_BRIDGE_PERF_CNT_EN
  assign perf_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_page_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_page_stream_bridge
// Description : Self-checking bench for page_stream_bridge against a
//               queue-based reference model of each channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_page_stream_bridge;

  localparam int PB    = 32;
  localparam int NI    = 2;
  localparam int NO    = 1;
  localparam int NCH   = NI + NO;
  localparam int DEPTH = 8;

  logic                ap_clk   = 1'b0;
  logic                ap_rst_n = 1'b0;
  logic                ap_start = 1'b0;
  logic                flush    = 1'b0;
  logic                ap_start_user;
  logic [NCH*32-1:0]   perf_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per channel, capacity DEPTH
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  bit          acc[NCH];
  logic [31:0] m_cnt[NCH];
  bit          m_start = 1'b0;

  page_stream_bridge_if #(.PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO)) bus ();

  page_stream_bridge #(
    .PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .FIFO_DEPTH_BITS(3)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .flush(flush),
    .ap_start_user(ap_start_user), .bus(bus), .perf_cnt(perf_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  // ---------------- model helpers ----------------
  function automatic int msize(int c);
    if (c == 0) return q0.size();
    if (c == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic logic [31:0] mhead(int c);
    if (c == 0) return q0[0];
    if (c == 1) return q1[0];
    return q2[0];
  endfunction

  task automatic mpush(int c, logic [31:0] d);
    if (c == 0) q0.push_back(d);
    else if (c == 1) q1.push_back(d);
    else q2.push_back(d);
  endtask

  task automatic mpop(int c);
    logic [31:0] t;
    if (c == 0) t = q0.pop_front();
    else if (c == 1) t = q1.pop_front();
    else t = q2.pop_front();
  endtask

  // ---------------- bench-driven inputs ----------------
  function automatic bit get_vld(int c);
    if (c < NI) return bus.vld_interface2user[c];
    return bus.Output_V_TVALID[c-NI];
  endfunction

  function automatic logic [31:0] get_din(int c);
    if (c < NI) return bus.dout_leaf_interface2user[c*PB +: PB];
    return bus.Output_V_TDATA[(c-NI)*PB +: PB];
  endfunction

  function automatic bit get_rdy(int c);
    if (c < NI) return bus.Input_V_TREADY[c];
    return bus.ack_interface2user[c-NI];
  endfunction

  task automatic set_in(int c, bit v, logic [31:0] d);
    if (c < NI) begin
      bus.vld_interface2user[c] = v;
      bus.dout_leaf_interface2user[c*PB +: PB] = d;
    end else begin
      bus.Output_V_TVALID[c-NI] = v;
      bus.Output_V_TDATA[(c-NI)*PB +: PB] = d;
    end
  endtask

  task automatic set_rdy(int c, bit r);
    if (c < NI) bus.Input_V_TREADY[c] = r;
    else bus.ack_interface2user[c-NI] = r;
  endtask

  // ---------------- DUT observation ----------------
  function automatic logic obs_ready(int c);
    if (c < NI) return bus.ack_user2interface[c];
    return bus.Output_V_TREADY[c-NI];
  endfunction

  function automatic logic obs_valid(int c);
    if (c < NI) return bus.Input_V_TVALID[c];
    return bus.vld_user2interface[c-NI];
  endfunction

  function automatic logic [31:0] obs_data(int c);
    if (c < NI) return bus.Input_V_TDATA[c*PB +: PB];
    return bus.din_leaf_user2interface[(c-NI)*PB +: PB];
  endfunction

  // Advance one clock and update the model from the inputs presented
  task automatic tick();
    bit          rdy[NCH];
    bit          pop[NCH];
    bit          push[NCH];
    logic [31:0] d[NCH];
    bit          fl;
    bit          st;
    for (int c = 0; c < NCH; c++) begin
      rdy[c]  = (msize(c) != DEPTH);
      pop[c]  = (msize(c) != 0) && get_rdy(c);
      push[c] = get_vld(c) && rdy[c];
      d[c]    = get_din(c);
    end
    fl = flush;
    st = ap_start;
    @(posedge ap_clk);
    if (st) m_start = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      acc[c] = push[c];
      if (push[c]) m_cnt[c] = m_cnt[c] + 32'd1;
    end
    if (fl) begin
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (pop[c])  mpop(c);
        if (push[c]) mpush(c, d[c]);
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge ap_clk);
    #1;
    checks++;
    if (bus.Input_V_TVALID !== 2'b00) begin
      failures++; $display("FAIL reset_in_valid: got %b expected 00", bus.Input_V_TVALID);
    end
    checks++;
    if (bus.vld_user2interface !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.vld_user2interface);
    end
    checks++;
    if (ap_start_user !== 1'b0) begin
      failures++; $display("FAIL reset_start_user: got %b expected 0", ap_start_user);
    end
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    checks++;
    if (bus.ack_user2interface !== 2'b11) begin
      failures++; $display("FAIL post_reset_ack: got %b expected 11", bus.ack_user2interface);
    end
    checks++;
    if (bus.Output_V_TREADY !== 1'b1) begin
      failures++; $display("FAIL post_reset_tready: got %b expected 1", bus.Output_V_TREADY);
    end
    checks++;
    if (bus.Input_V_TVALID !== 2'b00 || bus.vld_user2interface !== 1'b0) begin
      failures++; $display("FAIL post_reset_valid: got %b/%b expected 00/0",
                           bus.Input_V_TVALID, bus.vld_user2interface);
    end
    checks++;
    if (perf_cnt !== '0) begin
      failures++; $display("FAIL post_reset_perf: got %h expected 0", perf_cnt);
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] w[100];
    for (int i = 0; i < 100; i++) w[i] = $urandom;
    set_rdy(0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      set_in(0, 1'b1, w[i]);
      checks++;
      if (obs_ready(0) !== 1'b1) begin
        failures++; $display("FAIL concurrent_ack[%0d]: got %b expected 1", i, obs_ready(0));
      end
      tick();
      checks++;
      if (obs_valid(0) !== 1'b1 || obs_data(0) !== w[i]) begin
        failures++; $display("FAIL concurrent_out[%0d]: got v=%b d=%h expected v=1 d=%h",
                             i, obs_valid(0), obs_data(0), w[i]);
      end
    end
    set_in(0, 1'b0, 32'h0);
    tick();
    checks++;
    if (obs_valid(0) !== 1'b0) begin
      failures++; $display("FAIL concurrent_drain: got %b expected 0", obs_valid(0));
    end
    set_rdy(0, 1'b0);
`ifdef PAGE_BRIDGE_PERF_CNT_EN
    checks++;
    if (perf_cnt[31:0] !== 32'd100) begin
      failures++; $display("FAIL perf_ch0: got %0d expected 100", perf_cnt[31:0]);
    end
`else
    checks++;
    if (perf_cnt !== '0) begin
      failures++; $display("FAIL perf_tied: got %h expected 0", perf_cnt);
    end
`endif
  endtask

  task automatic test_single_word();
    set_in(0, 1'b1, 32'hDEADBEEF);
    tick();
    set_in(0, 1'b0, 32'h0);
    checks++;
    if (bus.Input_V_TVALID[0] !== 1'b1 || bus.Input_V_TDATA[31:0] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_word: got v=%b d=%h expected v=1 d=deadbeef",
                           bus.Input_V_TVALID[0], bus.Input_V_TDATA[31:0]);
    end
    checks++;
    if (bus.Input_V_TVALID[1] !== 1'b0) begin
      failures++; $display("FAIL single_word_ch1_idle: got %b expected 0", bus.Input_V_TVALID[1]);
    end
    set_rdy(0, 1'b1);
    tick();
    set_rdy(0, 1'b0);
    checks++;
    if (bus.Input_V_TVALID[0] !== 1'b0) begin
      failures++; $display("FAIL single_word_pop: got %b expected 0", bus.Input_V_TVALID[0]);
    end
  endtask

  task automatic test_fill_backpressure();
    int k;
    set_rdy(1, 1'b0);
    for (int w = 1; w <= 8; w++) begin
      set_in(1, 1'b1, w);
      checks++;
      if (obs_ready(1) !== 1'b1) begin
        failures++; $display("FAIL fill_ack[%0d]: got %b expected 1", w, obs_ready(1));
      end
      tick();
    end
    set_in(1, 1'b1, 32'd9);
    checks++;
    if (obs_ready(1) !== 1'b0) begin
      failures++; $display("FAIL fill_full_ack: got %b expected 0", obs_ready(1));
    end
    tick();
    tick();
    checks++;
    if (obs_ready(1) !== 1'b0 || obs_valid(1) !== 1'b1 || obs_data(1) !== 32'd1) begin
      failures++; $display("FAIL fill_hold: got ack=%b v=%b d=%h expected ack=0 v=1 d=1",
                           obs_ready(1), obs_valid(1), obs_data(1));
    end
    set_rdy(1, 1'b1);
    k = 1;
    for (int cyc = 0; cyc < 30 && k <= 9; cyc++) begin
      if (obs_valid(1) === 1'b1) begin
        checks++;
        if (obs_data(1) !== 32'(k)) begin
          failures++; $display("FAIL fill_order[%0d]: got %h expected %h", k, obs_data(1), k);
        end
        k++;
      end
      tick();
      if (acc[1]) set_in(1, 1'b0, 32'h0);
    end
    checks++;
    if (k != 10) begin
      failures++; $display("FAIL fill_count: got %0d words expected 9", k - 1);
    end
    checks++;
    if (obs_valid(1) !== 1'b0) begin
      failures++; $display("FAIL fill_empty: got %b expected 0", obs_valid(1));
    end
    set_rdy(1, 1'b0);
  endtask

  task automatic test_flush();
    set_rdy(2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      set_in(2, 1'b1, 32'hA0 + 32'(i));
      tick();
    end
    checks++;
    if (bus.vld_user2interface[0] !== 1'b1 || bus.din_leaf_user2interface !== 32'hA0) begin
      failures++; $display("FAIL flush_pre: got v=%b d=%h expected v=1 d=a0",
                           bus.vld_user2interface[0], bus.din_leaf_user2interface);
    end
    set_in(2, 1'b1, 32'hBAD);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_in(2, 1'b0, 32'h0);
    checks++;
    if (bus.vld_user2interface[0] !== 1'b0 || bus.Output_V_TREADY[0] !== 1'b1) begin
      failures++; $display("FAIL flush_clear: got v=%b rdy=%b expected v=0 rdy=1",
                           bus.vld_user2interface[0], bus.Output_V_TREADY[0]);
    end
    tick();
    checks++;
    if (bus.vld_user2interface[0] !== 1'b0) begin
      failures++; $display("FAIL flush_dropped: got %b expected 0", bus.vld_user2interface[0]);
    end
    set_in(2, 1'b1, 32'hC1);
    tick();
    set_in(2, 1'b0, 32'h0);
    checks++;
    if (bus.vld_user2interface[0] !== 1'b1 || bus.din_leaf_user2interface !== 32'hC1) begin
      failures++; $display("FAIL flush_after: got v=%b d=%h expected v=1 d=c1",
                           bus.vld_user2interface[0], bus.din_leaf_user2interface);
    end
    set_rdy(2, 1'b1);
    tick();
    set_rdy(2, 1'b0);
  endtask

  task automatic test_start();
    checks++;
    if (ap_start_user !== 1'b0) begin
      failures++; $display("FAIL start_idle: got %b expected 0", ap_start_user);
    end
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    checks++;
    if (ap_start_user !== 1'b1) begin
      failures++; $display("FAIL start_rise: got %b expected 1", ap_start_user);
    end
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (ap_start_user !== 1'b1) begin
      failures++; $display("FAIL start_sticky: got %b expected 1", ap_start_user);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (obs_ready(c) !== (msize(c) != DEPTH)) begin
          failures++; $display("FAIL rand_ready ch%0d cyc%0d: got %b expected %b",
                               c, cyc, obs_ready(c), msize(c) != DEPTH);
        end
        checks++;
        if (obs_valid(c) !== (msize(c) != 0)) begin
          failures++; $display("FAIL rand_valid ch%0d cyc%0d: got %b expected %b",
                               c, cyc, obs_valid(c), msize(c) != 0);
        end
        if (msize(c) != 0) begin
          checks++;
          if (obs_data(c) !== mhead(c)) begin
            failures++; $display("FAIL rand_data ch%0d cyc%0d: got %h expected %h",
                                 c, cyc, obs_data(c), mhead(c));
          end
        end
      end
      checks++;
      if (ap_start_user !== m_start) begin
        failures++; $display("FAIL rand_start cyc%0d: got %b expected %b", cyc, ap_start_user, m_start);
      end
      for (int c = 0; c < NCH; c++) begin
        if (!get_vld(c) || acc[c]) set_in(c, 1'($urandom_range(0, 1)), $urandom);
        set_rdy(c, ($urandom_range(0, 3) == 0));
      end
      flush    = ($urandom_range(0, 49) == 0);
      ap_start = ($urandom_range(0, 99) == 0);
      tick();
    end
    flush    = 1'b0;
    ap_start = 1'b0;
`ifdef PAGE_BRIDGE_PERF_CNT_EN
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (perf_cnt[c*32 +: 32] !== m_cnt[c]) begin
        failures++; $display("FAIL rand_perf ch%0d: got %0d expected %0d",
                             c, perf_cnt[c*32 +: 32], m_cnt[c]);
      end
    end
`endif
  endtask

  initial begin
    bus.dout_leaf_interface2user = '0;
    bus.vld_interface2user       = '0;
    bus.Input_V_TREADY           = '0;
    bus.Output_V_TDATA           = '0;
    bus.Output_V_TVALID          = '0;
    bus.ack_interface2user       = '0;
    for (int c = 0; c < NCH; c++) begin
      acc[c]   = 1'b0;
      m_cnt[c] = 32'd0;
    end
    test_reset();
    test_concurrent();
    test_single_word();
    test_fill_backpressure();
    test_flush();
    test_start();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
